// File: rtl/pixel_axis_packer_if.sv
// AXI-Stream beat bus carrying one packed pixel (nine direction values) per beat.
interface pixel_axis_packer_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int TDATA_W = 9 * DATA_WIDTH;

    logic               tvalid;
    logic               tready;
    logic [TDATA_W-1:0] tdata;
    logic [TDATA_W/8-1:0] tstrb;
    logic               tlast;

    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/pixel_axis_packer.sv
// Streams one frame of per-direction BRAM pixels onto AXI-Stream, one pixel per beat.
// A 2-entry buffer hides the 1-cycle BRAM latency; reads are issued against buffer credit.
module pixel_axis_packer #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_areset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     read_en,
    output logic [ADDRESS_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0]    n_in,
    input  logic [DATA_WIDTH-1:0]    null_in,
    input  logic [DATA_WIDTH-1:0]    ne_in,
    input  logic [DATA_WIDTH-1:0]    e_in,
    input  logic [DATA_WIDTH-1:0]    se_in,
    input  logic [DATA_WIDTH-1:0]    s_in,
    input  logic [DATA_WIDTH-1:0]    sw_in,
    input  logic [DATA_WIDTH-1:0]    w_in,
    input  logic [DATA_WIDTH-1:0]    nw_in,
    pixel_axis_packer_if.master      m00_axis
);
    localparam int NUM_LANES = 9;
    localparam int CNT_W     = ADDRESS_WIDTH + 1;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]         LAST_BEAT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic                                  last;
        logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  data;
    } beat_t;

    state_t                               state;
    logic [CNT_W-1:0]                     beat_cnt;
    logic                                 rd_inflight;
    logic [1:0]                           occ;
    logic                                 wr_ptr;
    logic                                 rd_ptr;
    beat_t                                fifo_mem [2];
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_vec;
    logic [DATA_WIDTH-1:0]                dir_in [NUM_LANES];
    logic                                 tvalid_i;
    logic                                 push;
    logic                                 pop;
    logic [2:0]                           pending;

    // Lane 0 sits in the low bits; order matches the DDR-side unpacker.
    assign dir_in = '{n_in, null_in, ne_in, e_in, se_in, s_in, sw_in, w_in, nw_in};

    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_lane
            assign lane_vec[l] = dir_in[l];
        end
    endgenerate

    assign tvalid_i = (occ != 2'd0);
    assign pop      = tvalid_i & m00_axis.tready;
    assign push     = rd_inflight;

    // Words held plus words still coming back from BRAM, after this cycle's pop.
    assign pending = {1'b0, occ} + {2'b00, rd_inflight} - {2'b00, pop};
    assign read_en = (state == STREAM) && (pending < 3'd2);

    assign m00_axis.tvalid = tvalid_i;
    assign m00_axis.tdata  = fifo_mem[rd_ptr].data;
    assign m00_axis.tlast  = tvalid_i & fifo_mem[rd_ptr].last;
    assign m00_axis.tstrb  = '1;

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            read_addr <= '0;
            beat_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (push)
                beat_cnt <= beat_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= STREAM;
                        busy      <= 1'b1;
                        read_addr <= '0;
                        beat_cnt  <= '0;
                    end
                end
                STREAM: begin
                    if (read_en) begin
                        read_addr <= read_addr + 1'b1;
                        if (read_addr == LAST_ADDR)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && fifo_mem[rd_ptr].last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // tlast is tagged on the way in so the head word alone decides end of packet.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            rd_inflight <= 1'b0;
            occ         <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            rd_inflight <= read_en;
            if (push) begin
                fifo_mem[wr_ptr] <= '{last: (beat_cnt == LAST_BEAT), data: lane_vec};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_pixel_axis_packer.sv
// Directed bench: DEPTH=8 (full rate, backpressure, restart, aborts), DEPTH=1 and DEPTH=2500.
module tb_pixel_axis_packer;
    localparam int DW = 16;
    localparam int TW = 9 * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] exp_word(input int a);
        logic [TW-1:0] w;
        for (int d = 0; d < 9; d++) w[d*DW +: DW] = 16'(a * 16 + d);
        return w;
    endfunction

    // DUT with DEPTH=8
    pixel_axis_packer_if #(.DATA_WIDTH(DW)) a8 ();
    logic start8 = 1'b0;
    logic busy8, done8, re8;
    logic [11:0] ad8;
    logic [DW-1:0] m8 [9];
    always @(posedge clk) if (re8) for (int d = 0; d < 9; d++) m8[d] <= 16'(ad8 * 16 + d);

    pixel_axis_packer #(.DATA_WIDTH(DW), .DEPTH(8), .ADDRESS_WIDTH(12)) u8 (
        .m00_axis_aclk(clk), .m00_axis_areset(rst), .start(start8), .busy(busy8), .done(done8),
        .read_en(re8), .read_addr(ad8), .n_in(m8[0]), .null_in(m8[1]), .ne_in(m8[2]),
        .e_in(m8[3]), .se_in(m8[4]), .s_in(m8[5]), .sw_in(m8[6]), .w_in(m8[7]), .nw_in(m8[8]),
        .m00_axis(a8));

    // DUT with DEPTH=1
    pixel_axis_packer_if #(.DATA_WIDTH(DW)) a1 ();
    logic start1 = 1'b0;
    logic busy1, done1, re1;
    logic [11:0] ad1;
    logic [DW-1:0] m1 [9];
    always @(posedge clk) if (re1) for (int d = 0; d < 9; d++) m1[d] <= 16'(ad1 * 16 + d);

    pixel_axis_packer #(.DATA_WIDTH(DW), .DEPTH(1), .ADDRESS_WIDTH(12)) u1 (
        .m00_axis_aclk(clk), .m00_axis_areset(rst), .start(start1), .busy(busy1), .done(done1),
        .read_en(re1), .read_addr(ad1), .n_in(m1[0]), .null_in(m1[1]), .ne_in(m1[2]),
        .e_in(m1[3]), .se_in(m1[4]), .s_in(m1[5]), .sw_in(m1[6]), .w_in(m1[7]), .nw_in(m1[8]),
        .m00_axis(a1));

    // DUT with default DEPTH=2500
    pixel_axis_packer_if #(.DATA_WIDTH(DW)) ad ();
    logic startd = 1'b0;
    logic busyd, doned, red;
    logic [11:0] add;
    logic [DW-1:0] md [9];
    always @(posedge clk) if (red) for (int d = 0; d < 9; d++) md[d] <= 16'(add * 16 + d);

    pixel_axis_packer #(.DATA_WIDTH(DW)) ud (
        .m00_axis_aclk(clk), .m00_axis_areset(rst), .start(startd), .busy(busyd), .done(doned),
        .read_en(red), .read_addr(add), .n_in(md[0]), .null_in(md[1]), .ne_in(md[2]),
        .e_in(md[3]), .se_in(md[4]), .s_in(md[5]), .sw_in(md[6]), .w_in(md[7]), .nw_in(md[8]),
        .m00_axis(ad));

    // DEPTH=8 monitor: beat log, stall stability, read credit
    logic [TW-1:0] bq [$];
    logic          lq [$];
    int            cq [$];
    int            dq [$];
    int            aq [$];
    bit            mon_hold = 1'b0;
    logic [TW-1:0] hold_d;
    logic          hold_l;
    int            issued = 0;
    int            popped = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_hold = 1'b0;
            issued   = 0;
            popped   = 0;
        end else begin
            if (mon_hold) begin
                chk("hold_valid", TW'(a8.tvalid), TW'(1));
                chk("hold_data", a8.tdata, hold_d);
                chk("hold_last", TW'(a8.tlast), TW'(hold_l));
            end
            mon_hold = a8.tvalid && !a8.tready;
            hold_d   = a8.tdata;
            hold_l   = a8.tlast;
            if (re8) begin
                aq.push_back(int'(ad8));
                issued++;
            end
            if (a8.tvalid && a8.tready) begin
                bq.push_back(a8.tdata);
                lq.push_back(a8.tlast);
                cq.push_back(cyc);
                popped++;
            end
            if (re8) chk("outstanding", TW'(issued - popped <= 2), TW'(1));
            if (done8) begin
                dq.push_back(cyc);
                chk("busy_at_done", TW'(busy8), TW'(0));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clrq();
        bq.delete(); lq.delete(); cq.delete(); dq.delete(); aq.delete();
    endtask

    task automatic wait_done8(input int budget);
        int t = 0;
        while (dq.size() == 0 && t < budget) begin
            step();
            t++;
        end
    endtask

    task automatic check_frame8(input string tag, input int k, input bit timed);
        chk({tag, "_nbeats"}, TW'(bq.size()), TW'(8));
        chk({tag, "_nreads"}, TW'(aq.size()), TW'(8));
        chk({tag, "_ndone"}, TW'(dq.size()), TW'(1));
        for (int i = 0; i < 8; i++) begin
            if (i < bq.size()) begin
                chk({tag, "_data"}, bq[i], exp_word(i));
                chk({tag, "_last"}, TW'(lq[i]), TW'(i == 7));
                if (timed) chk({tag, "_beatcyc"}, TW'(cq[i]), TW'(k + 3 + i));
            end
            if (i < aq.size()) chk({tag, "_addr"}, TW'(aq[i]), TW'(i));
        end
        if (timed && dq.size() > 0) chk({tag, "_donecyc"}, TW'(dq[0]), TW'(k + 11));
    endtask

    task automatic check_reset8(input string tag);
        chk({tag, "_busy"}, TW'(busy8), TW'(0));
        chk({tag, "_done"}, TW'(done8), TW'(0));
        chk({tag, "_read_en"}, TW'(re8), TW'(0));
        chk({tag, "_read_addr"}, TW'(ad8), TW'(0));
        chk({tag, "_tvalid"}, TW'(a8.tvalid), TW'(0));
        chk({tag, "_tlast"}, TW'(a8.tlast), TW'(0));
        chk({tag, "_tdata"}, a8.tdata, TW'(0));
        chk({tag, "_tstrb"}, TW'(a8.tstrb), TW'(18'h3ffff));
    endtask

    initial begin
        int k, t, stall, nl, nb, ng, nlast, lidx, fcyc, lcyc, dcyc, nd, maxa;
        logic [TW-1:0] bdata, tmp;
        logic blast;

        a8.tready = 1'b1;
        a1.tready = 1'b1;
        ad.tready = 1'b1;

        // reset state
        rst = 1'b1;
        step(3);
        @(negedge clk);
        check_reset8("por");
        chk("por_d1_tvalid", TW'(a1.tvalid), TW'(0));
        chk("por_dd_busy", TW'(busyd), TW'(0));
        step();
        rst = 1'b0;
        step(2);

        // reset while idle
        rst = 1'b1;
        @(negedge clk);
        check_reset8("idle_rst");
        step();
        rst = 1'b0;
        step(2);

        // full rate, DEPTH=8
        clrq();
        start8 = 1'b1;
        k = cyc;
        step();
        start8 = 1'b0;
        @(negedge clk);
        chk("k1_busy", TW'(busy8), TW'(1));
        chk("k1_read_en", TW'(re8), TW'(1));
        chk("k1_read_addr", TW'(ad8), TW'(0));
        chk("k1_tvalid", TW'(a8.tvalid), TW'(0));
        wait_done8(40);
        check_frame8("full", k, 1'b1);
        if (bq.size() > 5) begin
            tmp = bq[5];
            chk("beat5_null", TW'(tmp[31:16]), TW'(16'h0051));
        end
        step();
        @(negedge clk);
        chk("done_pulse_width", TW'(done8), TW'(0));

        // start pulsed while busy is ignored
        step(2);
        clrq();
        start8 = 1'b1;
        k = cyc;
        step();
        start8 = 1'b0;
        step(3);
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done8(40);
        step(15);
        check_frame8("rebusy", k, 1'b1);

        // backpressure: 5-cycle stall after beat 2, then random ready
        clrq();
        start8 = 1'b1;
        k = cyc;
        step();
        start8 = 1'b0;
        stall = 0;
        t = 0;
        while (dq.size() == 0 && t < 300) begin
            if (bq.size() >= 3 && stall < 5) begin
                a8.tready = 1'b0;
                stall++;
            end else if (stall >= 5) begin
                a8.tready = 1'($urandom_range(0, 1));
            end else begin
                a8.tready = 1'b1;
            end
            step();
            t++;
        end
        a8.tready = 1'b1;
        check_frame8("bp", k, 1'b0);
        chk("bp_stalled", TW'(stall), TW'(5));
        step(3);

        // reset mid-frame after beat 3
        clrq();
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        t = 0;
        while (bq.size() < 4 && t < 30) begin
            step();
            t++;
        end
        chk("abort_reached_beat3", TW'(bq.size()), TW'(4));
        rst = 1'b1;
        @(negedge clk);
        check_reset8("abort");
        step(2);
        rst = 1'b0;
        step(2);
        nl = 0;
        foreach (lq[i]) if (lq[i]) nl++;
        chk("abort_no_tlast", TW'(nl), TW'(0));
        chk("abort_no_done", TW'(dq.size()), TW'(0));
        clrq();
        start8 = 1'b1;
        k = cyc;
        step();
        start8 = 1'b0;
        wait_done8(40);
        check_frame8("restart", k, 1'b1);

        // DEPTH=1
        start1 = 1'b1;
        k = cyc;
        step();
        start1 = 1'b0;
        nb = 0; nd = 0; bdata = '0; blast = 1'b0; fcyc = -1; dcyc = -1;
        repeat (20) begin
            @(negedge clk);
            if (a1.tvalid && a1.tready) begin
                nb++;
                fcyc  = cyc;
                blast = a1.tlast;
                bdata = a1.tdata;
            end
            if (done1) begin
                nd++;
                dcyc = cyc;
            end
        end
        chk("d1_nbeats", TW'(nb), TW'(1));
        chk("d1_beatcyc", TW'(fcyc), TW'(k + 3));
        chk("d1_tlast", TW'(blast), TW'(1));
        chk("d1_data", bdata, exp_word(0));
        chk("d1_ndone", TW'(nd), TW'(1));
        chk("d1_donecyc", TW'(dcyc), TW'(k + 4));

        // DEPTH=2500 at full rate
        step();
        startd = 1'b1;
        k = cyc;
        step();
        startd = 1'b0;
        nb = 0; ng = 0; nlast = 0; lidx = -1; fcyc = -1; lcyc = -1; dcyc = -1; maxa = 0; t = 0;
        while (dcyc < 0 && t < 2700) begin
            @(negedge clk);
            if (red && int'(add) > maxa) maxa = int'(add);
            if (ad.tvalid && ad.tready) begin
                if (nb == 0) fcyc = cyc;
                lcyc = cyc;
                if (ad.tdata === exp_word(nb)) ng++;
                if (ad.tlast) begin
                    nlast++;
                    lidx = nb;
                end
                nb++;
            end
            if (doned) dcyc = cyc;
            t++;
        end
        chk("dd_nbeats", TW'(nb), TW'(2500));
        chk("dd_good_beats", TW'(ng), TW'(2500));
        chk("dd_ntlast", TW'(nlast), TW'(1));
        chk("dd_tlast_idx", TW'(lidx), TW'(2499));
        chk("dd_first_cyc", TW'(fcyc), TW'(k + 3));
        chk("dd_last_cyc", TW'(lcyc), TW'(k + 2502));
        chk("dd_max_addr", TW'(maxa), TW'(12'h9C3));
        chk("dd_donecyc", TW'(dcyc), TW'(k + 2503));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
